// File: rtl/pla_xgmii_path_sel.sv
// Frame-aware XGMII path selector: forwards one of CH_NUM registered streams and only
// changes source between frames, forcing a clean /E/ cut when no boundary arrives in time.
module pla_xgmii_path_sel #(
    parameter int CH_NUM      = 2,
    parameter int LANES       = 4,
    parameter int RST_CH      = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      I_sys_312m_clk,
    input  logic                      I_fpga_reset,
    input  logic [2:0]                I_sel,
    input  logic [CH_NUM*LANES-1:0]   I_txc,
    input  logic [CH_NUM*LANES*8-1:0] I_data,
    output logic [LANES-1:0]          O_txc,
    output logic [LANES*8-1:0]        O_data,
    output logic [2:0]                O_sel_cur,
    output logic                      O_switch_pending,
    output logic [15:0]               O_switch_cnt,
    output logic [7:0]                O_force_cnt
);

    localparam int                DATA_W   = 8 * LANES;
    localparam logic [2:0]        RST_SEL  = 3'(RST_CH);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        CTL_S    = 8'hFB;
    localparam logic [7:0]        CTL_T    = 8'hFD;
    localparam logic [DATA_W-1:0] IDLE_W   = {LANES{8'h07}};
    localparam logic [DATA_W-1:0] TERM_W   = {LANES{8'hFE}};

    typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;

    function automatic logic lane_is(input logic [LANES-1:0] txc, input logic [DATA_W-1:0] data,
                                     input int l, input logic [7:0] code);
        return txc[l] && (data[l*8 +: 8] == code);
    endfunction

    function automatic logic has_start(input logic [LANES-1:0] txc, input logic [DATA_W-1:0] data);
        logic r;
        r = 1'b0;
        for (int l = 0; l < LANES; l++)
            if (lane_is(txc, data, l, CTL_S)) r = 1'b1;
        return r;
    endfunction

    // The highest-numbered /S/ or /T/ in the word decides the frame state.
    function automatic logic frame_next(input logic in_frame_cur, input logic [LANES-1:0] txc,
                                        input logic [DATA_W-1:0] data);
        logic r;
        r = in_frame_cur;
        for (int l = 0; l < LANES; l++) begin
            if (lane_is(txc, data, l, CTL_S))      r = 1'b1;
            else if (lane_is(txc, data, l, CTL_T)) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [2:0]        sel_p1;
    logic [LANES-1:0]  txc_p1  [CH_NUM];
    logic [DATA_W-1:0] data_p1 [CH_NUM];

    // Stage 1: input capture
    always_ff @(posedge I_sys_312m_clk) begin
        if (I_fpga_reset) begin
            sel_p1 <= RST_SEL;
            for (int c = 0; c < CH_NUM; c++) begin
                txc_p1[c]  <= '1;
                data_p1[c] <= IDLE_W;
            end
        end else begin
            sel_p1 <= I_sel;
            for (int c = 0; c < CH_NUM; c++) begin
                txc_p1[c]  <= I_txc[c*LANES +: LANES];
                data_p1[c] <= I_data[c*DATA_W +: DATA_W];
            end
        end
    end

    logic [CH_NUM-1:0] in_frame;
    logic [CH_NUM-1:0] safe;

    always_comb begin
        safe = '0;
        for (int c = 0; c < CH_NUM; c++)
            safe[c] = !in_frame[c] && !has_start(txc_p1[c], data_p1[c]);
    end

    always_ff @(posedge I_sys_312m_clk) begin
        if (I_fpga_reset) begin
            in_frame <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++)
                in_frame[c] <= frame_next(in_frame[c], txc_p1[c], data_p1[c]);
        end
    end

    state_t            state, state_nx;
    logic [2:0]        cur_sel, cur_nx, req_hold, req;
    logic              req_vld;
    logic [15:0]       tmr, tmr_nx, sw_cnt;
    logic [7:0]        frc_cnt;
    logic              sw_inc, frc_inc, pend_p2;
    logic [LANES-1:0]  cur_txc, req_txc, txc_nx, txc_p2;
    logic [DATA_W-1:0] cur_data, req_data, data_nx, data_p2;
    logic              cur_safe, req_safe;

    // Out-of-range selects fall back to the last legal request.
    assign req_vld = ({1'b0, sel_p1} < 4'(CH_NUM));
    assign req     = req_vld ? sel_p1 : req_hold;

    always_ff @(posedge I_sys_312m_clk) begin
        if (I_fpga_reset)  req_hold <= RST_SEL;
        else if (req_vld)  req_hold <= sel_p1;
    end

    always_comb begin
        cur_txc  = '1;
        cur_data = IDLE_W;
        cur_safe = 1'b0;
        req_txc  = '1;
        req_data = IDLE_W;
        req_safe = 1'b0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (cur_sel == 3'(c)) begin
                cur_txc  = txc_p1[c];
                cur_data = data_p1[c];
                cur_safe = safe[c];
            end
            if (req == 3'(c)) begin
                req_txc  = txc_p1[c];
                req_data = data_p1[c];
                req_safe = safe[c];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur_sel;
        tmr_nx   = tmr;
        sw_inc   = 1'b0;
        frc_inc  = 1'b0;
        txc_nx   = cur_txc;
        data_nx  = cur_data;
        case (state)
            RUN: begin
                if (req != cur_sel) begin
                    if (cur_safe && req_safe) begin
                        cur_nx  = req;
                        sw_inc  = 1'b1;
                        txc_nx  = req_txc;
                        data_nx = req_data;
                    end else begin
                        state_nx = WAIT;
                        tmr_nx   = '0;
                    end
                end
            end
            WAIT: begin
                if (req != cur_sel && cur_safe && req_safe) begin
                    cur_nx   = req;
                    sw_inc   = 1'b1;
                    txc_nx   = req_txc;
                    data_nx  = req_data;
                    state_nx = RUN;
                end else if (req == cur_sel) begin
                    state_nx = RUN;
                end else if (tmr == TMO_LAST) begin
                    // Cut the old frame with an all-lane /E/ on the forced switch.
                    cur_nx   = req;
                    sw_inc   = 1'b1;
                    frc_inc  = 1'b1;
                    txc_nx   = '1;
                    data_nx  = TERM_W;
                    state_nx = FLUSH;
                end else begin
                    tmr_nx = tmr + 16'd1;
                end
            end
            FLUSH: begin
                if (cur_safe) begin
                    state_nx = RUN;
                end else begin
                    txc_nx  = '1;
                    data_nx = IDLE_W;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Stage 2: output and status registers
    always_ff @(posedge I_sys_312m_clk) begin
        if (I_fpga_reset) begin
            state   <= RUN;
            cur_sel <= RST_SEL;
            tmr     <= '0;
            sw_cnt  <= '0;
            frc_cnt <= '0;
            pend_p2 <= 1'b0;
            txc_p2  <= '1;
            data_p2 <= IDLE_W;
        end else begin
            state   <= state_nx;
            cur_sel <= cur_nx;
            tmr     <= tmr_nx;
            if (sw_inc)  sw_cnt  <= sw_cnt + 16'd1;
            if (frc_inc) frc_cnt <= sat_inc8(frc_cnt);
            pend_p2 <= (state_nx == WAIT);
            txc_p2  <= txc_nx;
            data_p2 <= data_nx;
        end
    end

    assign O_txc            = txc_p2;
    assign O_data           = data_p2;
    assign O_sel_cur        = cur_sel;
    assign O_switch_pending = pend_p2;
    assign O_switch_cnt     = sw_cnt;
    assign O_force_cnt      = frc_cnt;

endmodule

// File: tb/tb_pla_xgmii_path_sel.sv
// Directed bench for pla_xgmii_path_sel: a 4-lane instance driven from a vector table and
// an 8-lane instance exercising mixed /T/ + /S/ words.
module tb_pla_xgmii_path_sel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [2:0]  a_sel;
    logic [7:0]  a_txc;
    logic [63:0] a_data;
    logic [3:0]  a_otxc;
    logic [31:0] a_odata;
    logic [2:0]  a_cur;
    logic        a_pend;
    logic [15:0] a_sw;
    logic [7:0]  a_frc;

    logic [2:0]   b_sel;
    logic [15:0]  b_txc;
    logic [127:0] b_data;
    logic [7:0]   b_otxc;
    logic [63:0]  b_odata;
    logic [2:0]   b_cur;
    logic         b_pend;
    logic [15:0]  b_sw;
    logic [7:0]   b_frc;

    pla_xgmii_path_sel #(.CH_NUM(2), .LANES(4), .RST_CH(0), .TIMEOUT_CYC(16)) dut_a (
        .I_sys_312m_clk(clk), .I_fpga_reset(rst), .I_sel(a_sel), .I_txc(a_txc), .I_data(a_data),
        .O_txc(a_otxc), .O_data(a_odata), .O_sel_cur(a_cur), .O_switch_pending(a_pend),
        .O_switch_cnt(a_sw), .O_force_cnt(a_frc)
    );

    pla_xgmii_path_sel #(.CH_NUM(2), .LANES(8), .RST_CH(0), .TIMEOUT_CYC(64)) dut_b (
        .I_sys_312m_clk(clk), .I_fpga_reset(rst), .I_sel(b_sel), .I_txc(b_txc), .I_data(b_data),
        .O_txc(b_otxc), .O_data(b_odata), .O_sel_cur(b_cur), .O_switch_pending(b_pend),
        .O_switch_cnt(b_sw), .O_force_cnt(b_frc)
    );

    // 4-lane words as {txc, data}
    localparam logic [35:0] W_I = {4'hF, 32'h07070707};
    localparam logic [35:0] W_S = {4'h1, 32'h555555FB};
    localparam logic [35:0] W_T = {4'hF, 32'h070707FD};
    localparam logic [35:0] W_E = {4'hF, 32'hFEFEFEFE};
    localparam logic [35:0] W_C = {4'h0, 32'h1D1D1D1D};
    localparam logic [35:0] W_N = {4'h0, 32'h0A0A0A0A};

    // 8-lane words: /T/ in lane 2 followed by /S/ in lane 4
    localparam logic [71:0] B_I = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] B_S = {8'h01, 64'h55555555555555FB};
    localparam logic [71:0] B_W = {8'h14, 64'h333333FB33FD3333};
    localparam logic [71:0] B_T = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] B_C = {8'h00, 64'h1D1D1D1D1D1D1D1D};

    function automatic logic [35:0] wd(input int k);
        return {4'h0, 32'hD0000000 + 32'(k)};
    endfunction

    function automatic logic [35:0] we1(input int k);
        return {4'h0, 32'hE1000000 + 32'(k)};
    endfunction

    function automatic logic [71:0] bd(input int k);
        return {8'h00, 64'hD0D0000000000000 + 64'(k)};
    endfunction

    typedef struct {
        logic        rst;
        logic [2:0]  sel;
        logic [35:0] w0;
        logic [35:0] w1;
        logic [35:0] ew;
        logic [2:0]  ecur;
        logic        ep;
        logic [15:0] esw;
        logic [7:0]  ef;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic push(input int r, input int s, input logic [35:0] w0, input logic [35:0] w1,
                        input logic [35:0] ew, input int c, input int p, input int sw, input int f);
        vec_t v;
        v.rst  = (r != 0);
        v.sel  = 3'(s);
        v.w0   = w0;
        v.w1   = w1;
        v.ew   = ew;
        v.ecur = 3'(c);
        v.ep   = (p != 0);
        v.esw  = 16'(sw);
        v.ef   = 8'(f);
        tbl.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_b0(input logic [71:0] w);
        b_txc  = {B_C[71:64], w[71:64]};
        b_data = {B_C[63:0], w[63:0]};
    endtask

    task automatic chk_b(input string nm, input logic [71:0] ew, input int ec, input int ep);
        n_chk++;
        if ({b_otxc, b_odata} !== ew || b_cur !== 3'(ec) || b_pend !== (ep != 0)) begin
            n_bad++;
            $display("FAIL %s: got txc=%h data=%h cur=%0d pend=%0b, want txc=%h data=%h cur=%0d pend=%0d",
                     nm, b_otxc, b_odata, b_cur, b_pend, ew[71:64], ew[63:0], ec, ep);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        a_sel = 3'd0;
        a_txc = {W_C[35:32], W_I[35:32]};
        a_data = {W_C[31:0], W_I[31:0]};
        b_sel = 3'd0;
        set_b0(B_I);

        // Reset, then idle
        push(1, 0, W_I, W_C, W_I, 0, 0, 0, 0);
        push(1, 0, W_I, W_C, W_I, 0, 0, 0, 0);
        push(0, 0, W_I, W_C, W_I, 0, 0, 0, 0);
        // Request raised mid-frame then withdrawn
        push(0, 0, W_S,   W_C, W_I,   0, 0, 0, 0);
        push(0, 1, wd(1), W_C, W_S,   0, 0, 0, 0);
        push(0, 1, wd(2), W_C, wd(1), 0, 1, 0, 0);
        push(0, 0, wd(3), W_C, wd(2), 0, 1, 0, 0);
        push(0, 0, wd(4), W_C, wd(3), 0, 0, 0, 0);
        push(0, 0, W_T,   W_C, wd(4), 0, 0, 0, 0);
        push(0, 0, W_I,   W_C, W_T,   0, 0, 0, 0);
        push(0, 0, W_I,   W_C, W_I,   0, 0, 0, 0);
        // Out-of-range select is ignored even though both channels are safe
        for (int i = 0; i < 3; i++) push(0, 5, W_I, W_C, W_I, 0, 0, 0, 0);
        // Graceful switch after ch0 frame ends
        push(0, 0, W_S, W_C, W_I, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            push(0, (i >= 5) ? 1 : 0, wd(i + 1), W_C, (i == 0) ? W_S : wd(i), 0, (i >= 6) ? 1 : 0, 0, 0);
        push(0, 1, W_T, W_C, wd(16), 0, 1, 0, 0);
        push(0, 1, W_I, W_C, W_T,    0, 1, 0, 0);
        push(0, 1, W_I, W_C, W_C,    1, 0, 1, 0);
        push(0, 1, W_I, W_C, W_C,    1, 0, 1, 0);
        // Forced switch 1 -> 0 while ch1 never ends its frame
        push(0, 1, W_I, W_S,    W_C, 1, 0, 1, 0);
        push(0, 0, W_S, we1(0), W_S, 1, 0, 1, 0);
        for (int k = 1; k <= 16; k++) push(0, 0, wd(k), we1(k), we1(k - 1), 1, 1, 1, 0);
        push(0, 0, wd(17), we1(17), W_E, 0, 0, 2, 1);
        push(0, 0, wd(18), we1(18), W_I, 0, 0, 2, 1);
        push(0, 0, W_T,    we1(19), W_I, 0, 0, 2, 1);
        push(0, 0, W_N,    we1(20), W_I, 0, 0, 2, 1);
        push(0, 0, W_I,    we1(21), W_N, 0, 0, 2, 1);
        push(0, 0, W_I,    we1(22), W_I, 0, 0, 2, 1);
        // Second forced switch, then reset while flushing
        push(0, 1, W_S, W_S, W_I, 0, 0, 2, 1);
        for (int k = 1; k <= 16; k++) push(0, 1, wd(k), we1(k), (k == 1) ? W_S : wd(k - 1), 0, 1, 2, 1);
        push(0, 1, wd(17), we1(17), W_E, 1, 0, 3, 2);
        push(0, 1, wd(18), we1(18), W_I, 1, 0, 3, 2);
        push(1, 0, W_I, W_C, W_I, 0, 0, 0, 0);
        push(0, 0, W_I, W_C, W_I, 0, 0, 0, 0);
        push(0, 1, W_I, W_C, W_I, 0, 0, 0, 0);
        push(0, 1, W_I, W_C, W_C, 1, 0, 1, 0);
        push(0, 1, W_I, W_C, W_C, 1, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst    = tbl[i].rst;
            a_sel  = tbl[i].sel;
            a_txc  = {tbl[i].w1[35:32], tbl[i].w0[35:32]};
            a_data = {tbl[i].w1[31:0], tbl[i].w0[31:0]};
            tick();
            n_chk++;
            if ({a_otxc, a_odata} !== tbl[i].ew || a_cur !== tbl[i].ecur || a_pend !== tbl[i].ep ||
                a_sw !== tbl[i].esw || a_frc !== tbl[i].ef) begin
                n_bad++;
                $display("FAIL vec%0d: got txc=%h data=%h cur=%0d pend=%0b sw=%0d frc=%0d, want txc=%h data=%h cur=%0d pend=%0b sw=%0d frc=%0d",
                         i, a_otxc, a_odata, a_cur, a_pend, a_sw, a_frc, tbl[i].ew[35:32], tbl[i].ew[31:0],
                         tbl[i].ecur, tbl[i].ep, tbl[i].esw, tbl[i].ef);
            end
        end

        // 8-lane: /T/ then /S/ in one word keeps the channel in frame
        rst = 1'b1;
        b_sel = 3'd0;
        set_b0(B_I);
        tick();
        tick();
        rst = 1'b0;
        tick();
        set_b0(B_S);   tick();
        set_b0(B_W);   b_sel = 3'd1; tick(); chk_b("b_start", B_S, 0, 0);
        set_b0(bd(1)); tick(); chk_b("b_mixed_word", B_W, 0, 1);
        set_b0(bd(2)); tick(); chk_b("b_in_frame_held", bd(1), 0, 1);
        set_b0(B_T);   tick(); chk_b("b_still_framed", bd(2), 0, 1);
        set_b0(B_I);   tick(); chk_b("b_term_word", B_T, 0, 1);
        n = 0;
        while (b_cur !== 3'd1 && n < 10) begin
            tick();
            n++;
        end
        n_chk++;
        if (n != 1 || {b_otxc, b_odata} !== B_C || b_sw !== 16'd1 || b_frc !== 8'd0 || b_pend !== 1'b0) begin
            n_bad++;
            $display("FAIL b_switch: got cycles=%0d data=%h sw=%0d frc=%0d pend=%0b, want cycles=1 data=%h sw=1 frc=0 pend=0",
                     n, b_odata, b_sw, b_frc, b_pend, B_C[63:0]);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
